// File: rtl/i2c_burst_seq.sv
// i2c_burst_seq: Wishbone-side sequencer for the I2C master core.
//
// After reset it initialises the core once by writing the prescaler and
// enabling the core. After that it runs one burst transaction of
// 1..MAX_BURST bytes per start request. A transaction sends the slave
// address, 1 or 2 memory address bytes, and then either writes data bytes
// or does a repeated-start read. If the slave NACKs any byte the
// sequencer sends, the block issues a clean STOP and reports nack_err.
//
// Optional feature (macro I2C_SEQ_TIMEOUT_EN): a 16-bit watchdog on every
// TIP poll and every wait for wb_ack. When it expires, the transaction
// aborts and both nack_err and the extra port timeout_err are set.
//
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   start, rw           one-cycle request (accepted only when idle); 1=read
//   slave_addr          7-bit I2C slave address
//   mem_addr            memory address (only [7:0] when MEM_ADDR_BYTES=1)
//   burst_len           number of bytes minus 1
//   wr_data             write bytes; byte i = [8i+7:8i], byte 0 sent first
//   busy, done          busy for the whole transaction; done is a 1-cycle pulse
//   nack_err            slave NACK seen; held until the next start
//   rd_data_out         read bytes packed as for wr_data; unread bytes are 0
//   wb_*                8-bit Wishbone master port to the I2C core
//   wb_inta             core interrupt, unused (this design polls)
//   timeout_err         (I2C_SEQ_TIMEOUT_EN only) watchdog expired
module i2c_burst_seq #(
    parameter logic [15:0] PRESCALE       = 16'h00C8,
    parameter int          MEM_ADDR_BYTES = 1,
    parameter int          MAX_BURST      = 4,
    parameter int          LEN_W          = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   rw,
    input  logic [6:0]             slave_addr,
    input  logic [15:0]            mem_addr,
    input  logic [LEN_W-1:0]       burst_len,
    input  logic [8*MAX_BURST-1:0] wr_data,
    output logic                   busy,
    output logic                   done,
    output logic                   nack_err,
    output logic [8*MAX_BURST-1:0] rd_data_out,
    output logic [2:0]             wb_addr,
    output logic [7:0]             wb_wr_data,
    input  logic [7:0]             wb_rd_data,
    output logic                   wb_we,
    output logic                   wb_stb,
    output logic                   wb_cyc,
    input  logic                   wb_ack,
`ifdef I2C_SEQ_TIMEOUT_EN
    output logic                   timeout_err,
`endif
    input  logic                   wb_inta
);

    // Core register map
    localparam logic [2:0] A_PRER_LO = 3'd0, A_PRER_HI = 3'd1, A_CTR = 3'd2,
                           A_TXR_RXR = 3'd3, A_CR_SR  = 3'd4;
    // Command bytes written to CR
    localparam logic [7:0] C_STA_WR = 8'h90, C_WR = 8'h10, C_WR_STO = 8'h50,
                           C_RD_ACK = 8'h20, C_RD_NACK_STO = 8'h68, C_STO = 8'h40;

    typedef enum logic [3:0] {
        ST_INIT_LO, ST_INIT_HI, ST_INIT_CTR, ST_IDLE,
        ST_TXR, ST_CR, ST_POLL, ST_RXR, ST_ABORT, ST_ABORT_POLL
    } state_t;

    // Which byte of the transaction is currently being sent or received
    typedef enum logic [2:0] {
        PH_SADDR, PH_MADDR_HI, PH_MADDR_LO, PH_WDATA, PH_RSADDR, PH_RDATA
    } phase_t;

    state_t                 state, state_n;
    phase_t                 phase, phase_n;
    logic [LEN_W-1:0]       idx, idx_n, len_q, len_n;
    logic                   rw_q, rw_n;
    logic [6:0]             saddr_q, saddr_n;
    logic [15:0]            maddr_q, maddr_n;
    logic [8*MAX_BURST-1:0] wdata_q, wdata_n, rd_n;
    logic                   busy_n, done_n, nack_n;
    logic [2:0]             addr_n;
    logic [7:0]             wdat_n;
    logic                   we_n, stb_q, stb_n;

    logic                   acc_en, acc_we, acked, last, tip;
    logic [2:0]             acc_addr;
    logic [7:0]             acc_data, tx_byte, cmd;

`ifdef I2C_SEQ_TIMEOUT_EN
    logic [15:0] to_cnt, to_cnt_n;
    logic        to_pend, to_pend_n, to_err_n, waiting;
`else
    // Without the watchdog, every wait is unbounded.
`endif

    assign wb_stb = stb_q;
    assign wb_cyc = stb_q;

    logic unused_inta;
    assign unused_inta = wb_inta;

    assign acked = stb_q & wb_ack;
    assign last  = (idx == len_q);
    assign tip   = wb_rd_data[1];

    always_comb begin
        tx_byte = 8'h00;
        cmd     = C_WR;
        case (phase)
            PH_SADDR:    begin tx_byte = {saddr_q, 1'b0}; cmd = C_STA_WR; end
            PH_MADDR_HI: tx_byte = maddr_q[15:8];
            PH_MADDR_LO: tx_byte = maddr_q[7:0];
            PH_WDATA:    begin tx_byte = wdata_q[8*idx +: 8]; cmd = last ? C_WR_STO : C_WR; end
            PH_RSADDR:   begin tx_byte = {saddr_q, 1'b1}; cmd = C_STA_WR; end
            PH_RDATA:    cmd = last ? C_RD_NACK_STO : C_RD_ACK;
            default:     ;
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first, so partial assignment in
        // the branches below never infers a latch.
        state_n  = state;   phase_n = phase;    idx_n   = idx;
        rw_n     = rw_q;    saddr_n = saddr_q;  maddr_n = maddr_q;
        len_n    = len_q;   wdata_n = wdata_q;
        busy_n   = busy;    done_n  = 1'b0;     nack_n  = nack_err;
        rd_n     = rd_data_out;
        addr_n   = wb_addr; wdat_n  = wb_wr_data; we_n = wb_we; stb_n = stb_q;
        acc_en   = 1'b0;    acc_we  = 1'b0;
        acc_addr = 3'd0;    acc_data = 8'h00;
`ifdef I2C_SEQ_TIMEOUT_EN
        to_cnt_n  = 16'd0;
        to_pend_n = to_pend;
        to_err_n  = timeout_err;
`endif

        case (state)
            ST_INIT_LO: begin
                acc_en = 1'b1; acc_we = 1'b1; acc_addr = A_PRER_LO; acc_data = PRESCALE[7:0];
                if (acked) state_n = ST_INIT_HI;
            end
            ST_INIT_HI: begin
                acc_en = 1'b1; acc_we = 1'b1; acc_addr = A_PRER_HI; acc_data = PRESCALE[15:8];
                if (acked) state_n = ST_INIT_CTR;
            end
            ST_INIT_CTR: begin
                acc_en = 1'b1; acc_we = 1'b1; acc_addr = A_CTR; acc_data = 8'h80;
                if (acked) state_n = ST_IDLE;
            end
            ST_IDLE: begin
                if (start) begin
                    rw_n = rw; saddr_n = slave_addr; maddr_n = mem_addr;
                    len_n = burst_len; wdata_n = wr_data;
                    nack_n = 1'b0; rd_n = '0; busy_n = 1'b1;
                    idx_n = '0; phase_n = PH_SADDR; state_n = ST_TXR;
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_pend_n = 1'b0; to_err_n = 1'b0;
`endif
                end
            end
            ST_TXR: begin
                acc_en = 1'b1; acc_we = 1'b1; acc_addr = A_TXR_RXR; acc_data = tx_byte;
                if (acked) state_n = ST_CR;
            end
            ST_CR: begin
                acc_en = 1'b1; acc_we = 1'b1; acc_addr = A_CR_SR; acc_data = cmd;
                if (acked) state_n = ST_POLL;
            end
            ST_POLL: begin
                acc_en = 1'b1; acc_addr = A_CR_SR;
                if (acked && !tip) begin
                    // Read bytes carry no RxACK check; everything we send does.
                    if (phase == PH_RDATA)  state_n = ST_RXR;
                    else if (wb_rd_data[7]) state_n = ST_ABORT;
                    else begin
                        state_n = ST_TXR;
                        case (phase)
                            PH_SADDR:    phase_n = (MEM_ADDR_BYTES == 2) ? PH_MADDR_HI : PH_MADDR_LO;
                            PH_MADDR_HI: phase_n = PH_MADDR_LO;
                            PH_MADDR_LO: phase_n = rw_q ? PH_RSADDR : PH_WDATA;
                            PH_WDATA: begin
                                if (last) begin
                                    done_n = 1'b1; busy_n = 1'b0; state_n = ST_IDLE;
                                end else begin
                                    idx_n = idx + 1'b1;
                                end
                            end
                            PH_RSADDR: begin
                                // Read bytes need only a command, no TXR load.
                                phase_n = PH_RDATA; state_n = ST_CR;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_RXR: begin
                acc_en = 1'b1; acc_addr = A_TXR_RXR;
                if (acked) begin
                    rd_n[8*idx +: 8] = wb_rd_data;
                    if (last) begin
                        done_n = 1'b1; busy_n = 1'b0; state_n = ST_IDLE;
                    end else begin
                        idx_n = idx + 1'b1; state_n = ST_CR;
                    end
                end
            end
            ST_ABORT: begin
                acc_en = 1'b1; acc_we = 1'b1; acc_addr = A_CR_SR; acc_data = C_STO;
                if (acked) state_n = ST_ABORT_POLL;
            end
            ST_ABORT_POLL: begin
                acc_en = 1'b1; acc_addr = A_CR_SR;
                if (acked && !tip) begin
                    nack_n = 1'b1; done_n = 1'b1; busy_n = 1'b0; state_n = ST_IDLE;
`ifdef I2C_SEQ_TIMEOUT_EN
                    to_err_n = to_pend;
`endif
                end
            end
            default: state_n = ST_INIT_LO;
        endcase

        // Shared Wishbone handshake: launch when the strobe is low, and drop
        // it after the ack. The low cycle that follows is the mandatory gap
        // between accesses.
        if (acc_en) begin
            if (!stb_q) begin
                stb_n = 1'b1; addr_n = acc_addr; wdat_n = acc_data; we_n = acc_we;
            end else if (wb_ack) begin
                stb_n = 1'b0; we_n = 1'b0;
            end
        end

`ifdef I2C_SEQ_TIMEOUT_EN
        // The watchdog is only armed during transactions. An expiry while
        // already aborting ends the transaction directly, so it cannot loop.
        waiting = busy && ((stb_q && !wb_ack) || state == ST_POLL || state == ST_ABORT_POLL);
        if (waiting) begin
            to_cnt_n = to_cnt + 16'd1;
            if (to_cnt == 16'hFFFF) begin
                to_cnt_n = 16'd0; stb_n = 1'b0; we_n = 1'b0; to_pend_n = 1'b1;
                if (state == ST_ABORT || state == ST_ABORT_POLL) begin
                    nack_n = 1'b1; to_err_n = 1'b1; done_n = 1'b1;
                    busy_n = 1'b0; state_n = ST_IDLE;
                end else begin
                    state_n = ST_ABORT;
                end
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ST_INIT_LO;  phase <= PH_SADDR;  idx <= '0;  len_q <= '0;
            rw_q <= 1'b0;  saddr_q <= '0;  maddr_q <= '0;  wdata_q <= '0;
            busy <= 1'b0;  done <= 1'b0;  nack_err <= 1'b0;  rd_data_out <= '0;
            wb_addr <= '0;  wb_wr_data <= '0;  wb_we <= 1'b0;  stb_q <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
            to_cnt <= '0;  to_pend <= 1'b0;  timeout_err <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register updates from values that were all sampled at the same edge.
            state <= state_n;  phase <= phase_n;  idx <= idx_n;  len_q <= len_n;
            rw_q <= rw_n;  saddr_q <= saddr_n;  maddr_q <= maddr_n;  wdata_q <= wdata_n;
            busy <= busy_n;  done <= done_n;  nack_err <= nack_n;  rd_data_out <= rd_n;
            wb_addr <= addr_n;  wb_wr_data <= wdat_n;  wb_we <= we_n;  stb_q <= stb_n;
`ifdef I2C_SEQ_TIMEOUT_EN
            to_cnt <= to_cnt_n;  to_pend <= to_pend_n;  timeout_err <= to_err_n;
`endif
        end
    end

endmodule

// File: doc/i2c_burst_seq.md
Name: i2c_burst_seq

Overview:
- Parametrised Wishbone-side sequencer for the I2C master core; next generation of the single-byte read sequencer.
- Adds burst reads and writes of 1..MAX_BURST bytes, 1- or 2-byte memory addressing, a runtime-selectable direction, slave NACK detection with clean STOP, and one-time core initialisation.
- Sits between system control logic and the I2C master core's 8-bit Wishbone slave port.

Parameters:
- PRESCALE, 16'h00C8, value written to PRER_LO/PRER_HI at init.
- MEM_ADDR_BYTES, 1, memory address bytes sent after the slave address; legal values 1 or 2.
- MAX_BURST, 4, maximum bytes per transaction.
- LEN_W, 2, width of burst_len; burst_len encodes bytes-1; MAX_BURST must equal 2**LEN_W.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-low reset: rst==0 at a clk rising edge resets the block.
- start, in, 1, one-cycle request; sampled only in ST_IDLE.
- rw, in, 1, 1=read, 0=write; captured with start.
- slave_addr, in, 7, 7-bit slave address; captured with start.
- mem_addr, in, 16, memory address; only [7:0] used when MEM_ADDR_BYTES=1.
- burst_len, in, LEN_W, number of bytes minus 1.
- wr_data, in, 8*MAX_BURST, write bytes; byte i = [8i+7:8i], sent i=0 first.
- busy, out, 1, high from start acceptance until done.
- done, out, 1, one-cycle pulse at end of every transaction (ok or error).
- nack_err, out, 1, set with done when the slave NACKed; held until next start.
- rd_data_out, out, 8*MAX_BURST, read bytes packed as for wr_data; unread bytes hold 0.
- wb_addr, out, 3, Wishbone address.
- wb_wr_data, out, 8, Wishbone write data.
- wb_rd_data, in, 8, Wishbone read data.
- wb_we, out, 1, Wishbone write enable.
- wb_stb, out, 1, Wishbone strobe.
- wb_cyc, out, 1, Wishbone cycle.
- wb_ack, in, 1, Wishbone acknowledge.
- wb_inta, in, 1, core interrupt; ignored (polling design).

Behaviour:
- Reset values: busy=0, done=0, nack_err=0, rd_data_out=0, wb_stb=0, wb_cyc=0, wb_we=0, wb_addr=0, wb_wr_data=0. Internal state: ST_INIT_LO, init_done=0.
- All outputs are registered.
- Wishbone access:
  - stb, cyc, addr, data and we are asserted together and held until the first cycle wb_ack=1.
  - stb and cyc drop on the following cycle.
  - There is at least one idle cycle between accesses.
  - Read data is captured in the cycle wb_ack=1.
- Init, once after reset, with start ignored until complete:
  - ST_INIT_LO: PRER_LO(0) <= PRESCALE[7:0].
  - ST_INIT_HI: PRER_HI(1) <= PRESCALE[15:8].
  - ST_INIT_CTR: CTR(2) <= 8'h80.
  - Then go to ST_IDLE.
- ST_IDLE:
  - On start=1, capture rw, slave_addr, mem_addr, burst_len and wr_data.
  - Clear nack_err and rd_data_out; set busy. Byte counter idx=0.
- Byte-send step (used for the address phase and write data):
  - TXR(3) <= byte, then CR(4) <= cmd.
  - Then poll SR(4) reads until SR[1] (TIP)=0.
  - Then check SR[7] (RxACK): 1 means NACK and goes to ST_ABORT.
- Sequence:
  - Slave address with write bit: {slave_addr,0}, cmd 8'h90 (STA|WR).
  - Memory address: high byte first if MEM_ADDR_BYTES=2; cmd 8'h10.
  - Write (rw=0): bytes 0..burst_len with cmd 8'h10; the last byte uses 8'h50 (WR|STO).
  - Read (rw=1):
    - Repeated start {slave_addr,1}, cmd 8'h90.
    - Per byte: CR <= 8'h20 (RD, ACK), or 8'h68 (RD|NACK|STO) on the last byte.
    - Poll TIP=0, then read RXR(3) into byte idx. No RxACK check on read bytes.
- Completion: done=1 for one cycle, busy=0 the same cycle, return to ST_IDLE.
- ST_ABORT: CR <= 8'h40 (STO), poll TIP=0, then nack_err=1, done=1, busy=0.
- Boundaries:
  - burst_len=0 gives a single byte, which carries the STO command.
  - idx never exceeds burst_len.
  - start while busy is ignored.
  - Reset mid-transaction returns to ST_INIT_LO and re-initialises the core; the Wishbone cycle drops on the next edge.

Optional Feature:
- Macro: I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A 16-bit counter runs during every TIP poll and every wait for wb_ack.
  - On reaching 16'hFFFF it goes to ST_ABORT, and the completion sets nack_err=1 plus output timeout_err=1 (extra port, 1 bit, reset 0, cleared on start).
- Undefined: no counter, no timeout_err port, and waits are unbounded.

Test Plan:
- Reset then idle with a model core acking in 1 cycle -> WB writes addr0=8'hC8, addr1=8'h00, addr2=8'h80 in order; start during init is ignored; busy stays 0.
- Read, MEM_ADDR_BYTES=1, slave 7'h10, mem 8'h06, burst_len=0, slave returns 8'hA5 -> TXR 8'h20/CR 8'h90, TXR 8'h06/CR 8'h10, TXR 8'h21/CR 8'h90, CR 8'h68; rd_data_out[7:0]=8'hA5; done pulse; nack_err=0.
- Read burst_len=3 returning 11,22,33,44 -> CR 8'h20 ×3 then 8'h68; rd_data_out=32'h44332211.
- Write burst_len=1, wr_data=16'hBEEF, MEM_ADDR_BYTES=2, mem_addr=16'h1234 -> TXR sequence 8'h20, 8'h12, 8'h34, 8'hEF, 8'hBE; last CR=8'h50.
- Slave NACK on the address byte (SR[7]=1) -> CR 8'h40 issued, done=1, nack_err=1, no further TXR writes.
- rst=0 asserted mid-burst while wb_cyc=1 -> next edge wb_cyc=0, busy=0, init sequence replays.
